// File: rtl/channel_llr_pingpong_scheduler.sv
// Ping-pong scheduler for two channel-LLR registers in front of the SC decoder.
// Optional feature: define SCHED_FRAME_CNT_EN to add the frames_decoded counter output.
module channel_llr_pingpong_scheduler #(
  parameter int unsigned n = 3,
  parameter int unsigned p = 1
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic                          frame_valid,
  output logic                          frame_ready,
  output logic [1:0]                    buf_data_valid,
  output logic [1:0]                    buf_decoder_busy,
  output logic [1:0]                    buf_decoder_done,
  output logic                          decoder_start,
  input  logic                          decoder_done,
  input  logic                          llr_rd_en,
  input  logic [(2**(n-p-1))-1:0]       llr_rd_addr,
  output logic [1:0]                    buf_rd_en,
  output logic [(2**(n-p-1))-1:0]       buf_rd_addr,
  output logic                          dout_sel,
  output logic                          protocol_err
`ifdef SCHED_FRAME_CNT_EN
  ,
  output logic [15:0]                   frames_decoded
`endif
);

  localparam int unsigned AW = 2**(n-p-1);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_START = 2'd1,
    ST_BUSY  = 2'd2
  } state_e;

  typedef enum logic [1:0] {
    BUF_EMPTY = 2'd0,
    BUF_FULL  = 2'd1,
    BUF_DEC   = 2'd2
  } buf_e;

  state_e r_state;
  state_e w_state_nxt;
  buf_e   r_bst     [2];
  buf_e   w_bst_nxt [2];
  logic   r_wr_ptr;
  logic   r_rd_ptr;
  logic   r_protocol_err;

  logic   w_frame_ready;
  logic   w_accept;
  logic   w_start;
  logic   w_release;
  logic   w_err_evt;

  // Load path: ready is decoded from registered state only
  always_comb begin
    w_frame_ready  = (r_bst[r_wr_ptr] == BUF_EMPTY);
    w_accept       = frame_valid & w_frame_ready;
    buf_data_valid = 2'b00;
    if (w_accept) buf_data_valid[r_wr_ptr] = 1'b1;
  end

  // Decode FSM: next state and per-cycle strobes
  always_comb begin
    w_state_nxt      = r_state;
    decoder_start    = 1'b0;
    buf_rd_en        = 2'b00;
    buf_decoder_done = 2'b00;
    w_start          = 1'b0;
    w_release        = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (r_bst[r_rd_ptr] == BUF_FULL) w_state_nxt = ST_START;
      end
      ST_START: begin
        decoder_start = 1'b1;
        w_start       = 1'b1;
        w_state_nxt   = ST_BUSY;
      end
      ST_BUSY: begin
        buf_rd_en[r_rd_ptr]        = llr_rd_en;
        buf_decoder_done[r_rd_ptr] = decoder_done;
        if (decoder_done) begin
          w_release   = 1'b1;
          w_state_nxt = ST_IDLE;
        end
      end
      default: w_state_nxt = ST_IDLE;
    endcase
  end

  // Load, start and release always target different registers, so they compose
  always_comb begin
    for (int i = 0; i < 2; i++) w_bst_nxt[i] = r_bst[i];
    if (w_accept)  w_bst_nxt[r_wr_ptr] = BUF_FULL;
    if (w_start)   w_bst_nxt[r_rd_ptr] = BUF_DEC;
    if (w_release) w_bst_nxt[r_rd_ptr] = BUF_EMPTY;
  end

  assign w_err_evt = (frame_valid & ~w_frame_ready) |
                     (decoder_done & (r_state != ST_BUSY));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state        <= ST_IDLE;
      r_bst[0]       <= BUF_EMPTY;
      r_bst[1]       <= BUF_EMPTY;
      r_wr_ptr       <= 1'b0;
      r_rd_ptr       <= 1'b0;
      r_protocol_err <= 1'b0;
    end else begin
      r_state  <= w_state_nxt;
      r_bst[0] <= w_bst_nxt[0];
      r_bst[1] <= w_bst_nxt[1];
      if (w_accept)  r_wr_ptr <= ~r_wr_ptr;
      if (w_release) r_rd_ptr <= ~r_rd_ptr;
      if (w_err_evt) r_protocol_err <= 1'b1;
    end
  end

  assign frame_ready         = w_frame_ready;
  assign buf_decoder_busy[0] = (r_bst[0] != BUF_EMPTY);
  assign buf_decoder_busy[1] = (r_bst[1] != BUF_EMPTY);
  assign buf_rd_addr         = AW'(llr_rd_addr);
  assign dout_sel            = r_rd_ptr;
  assign protocol_err        = r_protocol_err;

`ifdef SCHED_FRAME_CNT_EN
  logic [15:0] r_frames_decoded;

  // Count of completed decodes, wraps naturally at 16 bits
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_frames_decoded <= 16'd0;
    else if (w_release) r_frames_decoded <= r_frames_decoded + 16'd1;
  end

  assign frames_decoded = r_frames_decoded;
`endif

endmodule

// File: tb/tb_channel_llr_pingpong_scheduler.sv
// Bench for channel_llr_pingpong_scheduler: directed vector table, hand sequences,
// and randomized traffic against a queue-based reference model.
module tb_channel_llr_pingpong_scheduler;

  logic       clk;
  logic       rst_n;
  logic       frame_valid;
  logic       frame_ready;
  logic [1:0] buf_data_valid;
  logic [1:0] buf_decoder_busy;
  logic [1:0] buf_decoder_done;
  logic       decoder_start;
  logic       decoder_done;
  logic       llr_rd_en;
  logic [1:0] llr_rd_addr;
  logic [1:0] buf_rd_en;
  logic [1:0] buf_rd_addr;
  logic       dout_sel;
  logic       protocol_err;
`ifdef SCHED_FRAME_CNT_EN
  logic [15:0] frames_decoded;
`endif

  int total = 0;
  int bad   = 0;

  channel_llr_pingpong_scheduler #(.n(3), .p(1)) dut (
    .clk              (clk),
    .rst_n            (rst_n),
    .frame_valid      (frame_valid),
    .frame_ready      (frame_ready),
    .buf_data_valid   (buf_data_valid),
    .buf_decoder_busy (buf_decoder_busy),
    .buf_decoder_done (buf_decoder_done),
    .decoder_start    (decoder_start),
    .decoder_done     (decoder_done),
    .llr_rd_en        (llr_rd_en),
    .llr_rd_addr      (llr_rd_addr),
    .buf_rd_en        (buf_rd_en),
    .buf_rd_addr      (buf_rd_addr),
    .dout_sel         (dout_sel),
    .protocol_err     (protocol_err)
`ifdef SCHED_FRAME_CNT_EN
    ,
    .frames_decoded   (frames_decoded)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic       fv;
    logic       done;
    logic       rden;
    logic [1:0] addr;
    logic       ready;
    logic [1:0] dv;
    logic [1:0] busy;
    logic       start;
    logic [1:0] bdone;
    logic [1:0] rden_o;
    logic       sel;
    logic       err;
  } vec_t;

  vec_t tbl [19];

  // Reference model state: occupancy, arrival-order queue, decode slot
  bit m_occ [2];
  int m_q [$];
  int m_wr, m_rd, m_busy_reg, m_start_reg;
  bit m_starting, m_err;
  int m_cnt;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic drive(input logic fv, input logic dn, input logic re, input logic [1:0] ad);
    frame_valid  = fv;
    decoder_done = dn;
    llr_rd_en    = re;
    llr_rd_addr  = ad;
  endtask

  task automatic do_reset();
    @(negedge clk);
    drive(1'b0, 1'b0, 1'b0, 2'd0);
    rst_n = 1'b0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    m_occ[0] = 0; m_occ[1] = 0;
    m_q.delete();
    m_wr = 0; m_rd = 0; m_busy_reg = -1; m_start_reg = 0;
    m_starting = 0; m_err = 0; m_cnt = 0;
  endtask

  // One randomized cycle: drive at negedge, compare, then advance the model
  task automatic rand_cycle(input bit clean);
    logic fv, dn, re;
    logic [1:0] ad;
    logic exp_ready;
    logic [1:0] exp_dv, exp_rden, exp_bdone, exp_busy;
    bit accept, idle;
    @(negedge clk);
    exp_ready = !m_occ[m_wr];
    fv = ($urandom_range(0, 2) == 0);
    if (clean && !exp_ready) fv = 1'b0;
    dn = ($urandom_range(0, 3) == 0);
    if (clean && m_busy_reg < 0) dn = 1'b0;
    re = $urandom_range(0, 1) == 1;
    ad = 2'($urandom_range(0, 3));
    drive(fv, dn, re, ad);
    #1;
    accept    = fv && exp_ready;
    exp_dv    = accept ? (2'b01 << m_wr) : 2'b00;
    exp_busy  = {1'(m_occ[1]), 1'(m_occ[0])};
    exp_rden  = (m_busy_reg >= 0 && re) ? (2'b01 << m_busy_reg) : 2'b00;
    exp_bdone = (m_busy_reg >= 0 && dn) ? (2'b01 << m_busy_reg) : 2'b00;
    chk("rand_outputs",
        32'({frame_ready, buf_data_valid, buf_decoder_busy, decoder_start,
             buf_decoder_done, buf_rd_en, buf_rd_addr, dout_sel, protocol_err}),
        32'({exp_ready, exp_dv, exp_busy, 1'(m_starting),
             exp_bdone, exp_rden, ad, 1'(m_rd), 1'(m_err)}));
`ifdef SCHED_FRAME_CNT_EN
    chk("rand_frames_decoded", 32'(frames_decoded), 32'(m_cnt[15:0]));
`endif
    idle = (m_busy_reg < 0) && !m_starting;
    if (dn && m_busy_reg >= 0) begin
      m_occ[m_busy_reg] = 0;
      m_busy_reg = -1;
      m_rd ^= 1;
      m_cnt++;
    end else if (dn) begin
      m_err = 1;
    end
    if (fv && !exp_ready) m_err = 1;
    if (m_starting) begin
      m_busy_reg = m_start_reg;
      m_starting = 0;
    end else if (idle && m_q.size() > 0) begin
      m_start_reg = m_q.pop_front();
      m_starting  = 1;
    end
    if (accept) begin
      m_occ[m_wr] = 1;
      m_q.push_back(m_wr);
      m_wr ^= 1;
    end
  endtask

  initial begin
    rst_n = 1'b0;
    drive(1'b0, 1'b0, 1'b0, 2'd0);

    // fv done rden addr | ready dv busy start bdone rden_o sel err
    tbl[0]  = '{1'b0, 1'b0, 1'b0, 2'd0, 1'b1, 2'b00, 2'b00, 1'b0, 2'b00, 2'b00, 1'b0, 1'b0};
    tbl[1]  = '{1'b1, 1'b0, 1'b0, 2'd0, 1'b1, 2'b01, 2'b00, 1'b0, 2'b00, 2'b00, 1'b0, 1'b0};
    tbl[2]  = '{1'b0, 1'b0, 1'b0, 2'd0, 1'b1, 2'b00, 2'b01, 1'b0, 2'b00, 2'b00, 1'b0, 1'b0};
    tbl[3]  = '{1'b0, 1'b0, 1'b1, 2'd1, 1'b1, 2'b00, 2'b01, 1'b1, 2'b00, 2'b00, 1'b0, 1'b0};
    tbl[4]  = '{1'b0, 1'b0, 1'b1, 2'd2, 1'b1, 2'b00, 2'b01, 1'b0, 2'b00, 2'b01, 1'b0, 1'b0};
    tbl[5]  = '{1'b0, 1'b1, 1'b0, 2'd0, 1'b1, 2'b00, 2'b01, 1'b0, 2'b01, 2'b00, 1'b0, 1'b0};
    tbl[6]  = '{1'b0, 1'b0, 1'b0, 2'd0, 1'b1, 2'b00, 2'b00, 1'b0, 2'b00, 2'b00, 1'b1, 1'b0};
    tbl[7]  = '{1'b1, 1'b0, 1'b0, 2'd0, 1'b1, 2'b10, 2'b00, 1'b0, 2'b00, 2'b00, 1'b1, 1'b0};
    tbl[8]  = '{1'b1, 1'b0, 1'b0, 2'd0, 1'b1, 2'b01, 2'b10, 1'b0, 2'b00, 2'b00, 1'b1, 1'b0};
    tbl[9]  = '{1'b1, 1'b0, 1'b0, 2'd0, 1'b0, 2'b00, 2'b11, 1'b1, 2'b00, 2'b00, 1'b1, 1'b0};
    tbl[10] = '{1'b0, 1'b0, 1'b1, 2'd2, 1'b0, 2'b00, 2'b11, 1'b0, 2'b00, 2'b10, 1'b1, 1'b1};
    tbl[11] = '{1'b0, 1'b1, 1'b0, 2'd0, 1'b0, 2'b00, 2'b11, 1'b0, 2'b10, 2'b00, 1'b1, 1'b1};
    tbl[12] = '{1'b1, 1'b0, 1'b0, 2'd0, 1'b1, 2'b10, 2'b01, 1'b0, 2'b00, 2'b00, 1'b0, 1'b1};
    tbl[13] = '{1'b0, 1'b0, 1'b1, 2'd3, 1'b0, 2'b00, 2'b11, 1'b1, 2'b00, 2'b00, 1'b0, 1'b1};
    tbl[14] = '{1'b0, 1'b1, 1'b0, 2'd0, 1'b0, 2'b00, 2'b11, 1'b0, 2'b01, 2'b00, 1'b0, 1'b1};
    tbl[15] = '{1'b0, 1'b0, 1'b0, 2'd0, 1'b1, 2'b00, 2'b10, 1'b0, 2'b00, 2'b00, 1'b1, 1'b1};
    tbl[16] = '{1'b0, 1'b0, 1'b1, 2'd1, 1'b1, 2'b00, 2'b10, 1'b1, 2'b00, 2'b00, 1'b1, 1'b1};
    tbl[17] = '{1'b0, 1'b1, 1'b1, 2'd1, 1'b1, 2'b00, 2'b10, 1'b0, 2'b10, 2'b10, 1'b1, 1'b1};
    tbl[18] = '{1'b0, 1'b0, 1'b1, 2'd2, 1'b1, 2'b00, 2'b00, 1'b0, 2'b00, 2'b00, 1'b0, 1'b1};

    // Directed table from a fresh reset
    do_reset();
    for (int i = 0; i < 19; i++) begin
      if (i != 0) @(negedge clk);
      drive(tbl[i].fv, tbl[i].done, tbl[i].rden, tbl[i].addr);
      #1;
      chk($sformatf("tbl%0d_ready", i), 32'(frame_ready), 32'(tbl[i].ready));
      chk($sformatf("tbl%0d_dv", i), 32'(buf_data_valid), 32'(tbl[i].dv));
      chk($sformatf("tbl%0d_busy", i), 32'(buf_decoder_busy), 32'(tbl[i].busy));
      chk($sformatf("tbl%0d_start", i), 32'(decoder_start), 32'(tbl[i].start));
      chk($sformatf("tbl%0d_bdone", i), 32'(buf_decoder_done), 32'(tbl[i].bdone));
      chk($sformatf("tbl%0d_rden", i), 32'(buf_rd_en), 32'(tbl[i].rden_o));
      chk($sformatf("tbl%0d_addr", i), 32'(buf_rd_addr), 32'(tbl[i].addr));
      chk($sformatf("tbl%0d_sel", i), 32'(dout_sel), 32'(tbl[i].sel));
      chk($sformatf("tbl%0d_err", i), 32'(protocol_err), 32'(tbl[i].err));
    end

    // Reset asserted mid-decode: immediate idle outputs, no done pulse
    do_reset();
    @(negedge clk); drive(1'b1, 1'b0, 1'b0, 2'd0);
    @(negedge clk); drive(1'b0, 1'b0, 1'b0, 2'd0);
    @(negedge clk);
    @(negedge clk); drive(1'b0, 1'b0, 1'b1, 2'd1);
    #1;
    chk("busy_rden_before_reset", 32'(buf_rd_en), 32'h1);
    @(negedge clk);
    drive(1'b0, 1'b1, 1'b1, 2'd0);
    rst_n = 1'b0;
    #1;
    chk("rst_ready", 32'(frame_ready), 32'h1);
    chk("rst_busy", 32'(buf_decoder_busy), 32'h0);
    chk("rst_bdone", 32'(buf_decoder_done), 32'h0);
    chk("rst_rden", 32'(buf_rd_en), 32'h0);
    chk("rst_start_sel_err", 32'({decoder_start, dout_sel, protocol_err}), 32'h0);
    @(negedge clk);
    drive(1'b0, 1'b0, 1'b0, 2'd0);
    rst_n = 1'b1;

    // decoder_done while idle is flagged and produces no per-register pulse
    @(negedge clk); drive(1'b0, 1'b1, 1'b0, 2'd0);
    #1;
    chk("idle_done_bdone", 32'(buf_decoder_done), 32'h0);
    chk("idle_done_err_pre", 32'(protocol_err), 32'h0);
    @(negedge clk); drive(1'b0, 1'b0, 1'b0, 2'd0);
    #1;
    chk("idle_done_err_post", 32'(protocol_err), 32'h1);
    chk("idle_done_busy", 32'(buf_decoder_busy), 32'h0);

    // Randomized traffic against the reference model
    do_reset();
    for (int c = 0; c < 1500; c++) rand_cycle(1'b1);
    for (int c = 0; c < 1500; c++) rand_cycle(1'b0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
